if_id_buffer: RTL and testbench
===============================

IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 Parameter: DEPTH, 2, number of buffered fetch entries; legal values 2 or 4 only.
REQ-002 Port: clk  input  1  single clock; all state updates on posedge.
REQ-003 Port: CLR_n  input  1  reset; synchronous, active-low.
REQ-004 Port: in_valid  input  1  fetch stage presents an instruction this cycle.
REQ-005 Port: in_IR  input  32  fetched instruction word.
REQ-006 Port: in_PC  input  32  PC (word index) of in_IR.
REQ-007 Port: in_ready  output  1  buffer accepts an entry this cycle.
REQ-008 Port: flush  input  1  discard all buffered and incoming entries (taken branch/jump).
REQ-009 Port: out_valid  output  1  head entry available to decode.
REQ-010 Port: out_IR  output  32  head instruction word.
REQ-011 Port: out_PC  output  32  head PC.
REQ-012 Port: out_ready  input  1  decode consumes head this cycle.
REQ-013 Port: count  output  3  number of occupied entries, 0..DEPTH.

Function
REQ-014 Storage SHALL be a circular buffer of DEPTH entries, each {IR[31:0], PC[31:0]}, with read pointer, write pointer and occupancy counter.
REQ-015 Push SHALL occur on a clock edge when in_valid && in_ready && flush==0; entry written at write pointer, write pointer advances.
REQ-016 Pop SHALL occur on a clock edge when out_valid && out_ready && flush==0; read pointer advances.
REQ-017 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-018 in_ready SHALL equal (count < DEPTH), registered state only; no combinational path from out_ready or flush.
REQ-019 out_valid SHALL equal (count != 0); no combinational path from in_valid (no bypass).
REQ-020 Latency: an entry pushed at edge N SHALL be visible on out_valid/out_IR/out_PC after edge N when buffer was empty.
REQ-021 out_IR and out_PC SHALL present the entry at the read pointer when out_valid=1, and 32'h0 (NOP) when out_valid=0.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and both pointers advanced; order preserved (FIFO).
REQ-023 When full (count==DEPTH), in_ready=0; in_valid SHALL be ignored even if out_ready=1 that cycle.
REQ-024 When empty, out_ready SHALL be ignored; count never underflows.
REQ-025 flush=1 SHALL on the next edge set count=0, read and write pointers to 0, and drop any same-cycle push and pop.
REQ-026 Entry contents need not be cleared by flush; outputs SHALL read 0 via REQ-021.
REQ-027 count SHALL be zero-extended to 3 bits for DEPTH=2.

Reset
REQ-028 CLR_n=0 at a clock edge SHALL set count=0, both pointers=0, all storage entries to 0.
REQ-029 After reset: out_valid=0, in_ready=1, out_IR=0, out_PC=0, count=0.
REQ-030 Reset SHALL take priority over flush, push and pop in the same cycle.
REQ-031 Reset asserted mid-operation SHALL discard all entries with no partial pop or push observed.

Verification
REQ-032 Reset then in_valid=1, IR=32'h20080005, PC=0, out_ready=0 for one edge -> out_valid=1, out_IR=32'h20080005, out_PC=0, count=1, in_ready=1.
REQ-033 DEPTH=2, out_ready=0, push PC=0,1,2 on three edges -> count=2, in_ready=0 after second edge, third push dropped; then out_ready=1 two edges -> out_PC 0 then 1, count 0.
REQ-034 count=1, in_valid=1 and out_ready=1 same edge for 8 edges with PC=1..8 -> count stays 1, out_PC sequence 0,1,..,7 with pointer wrap, no loss.
REQ-035 count=2, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_IR=0, in_ready=1; flushed-cycle input never appears.
REQ-036 count=2, CLR_n=0 with flush=0, in_valid=1 -> next cycle count=0, out_valid=0, out_PC=0, in_ready=1.

Source files
------------

// File: rtl/if_id_buffer.sv
`default_nettype none
// ============================================================================
// Module   : if_id_buffer
// Brief    : Circular IF/ID decoupling buffer of fetched {IR, PC} entries.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        CLR_n,
  input  logic        in_valid,
  input  logic [31:0] in_IR,
  input  logic [31:0] in_PC,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_valid,
  output logic [31:0] out_IR,
  output logic [31:0] out_PC,
  input  logic        out_ready,
  output logic [2:0]  count
);

  localparam int              PTR_W   = (DEPTH == 4) ? 2 : 1;
  localparam logic [PTR_W-1:0] c_last  = PTR_W'(DEPTH - 1);
  localparam logic [2:0]       c_depth = 3'(DEPTH);

  logic [31:0]      r_mem_ir [DEPTH];
  logic [31:0]      r_mem_pc [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [2:0]       r_count;

  logic             w_valid;
  logic             w_push;
  logic             w_pop;
  logic [PTR_W-1:0] w_rd_next;
  logic [PTR_W-1:0] w_wr_next;

  // Handshake flags depend on registered occupancy only.
  assign w_valid  = (r_count != 3'd0);
  assign in_ready = (r_count < c_depth);
  assign w_push   = in_valid && in_ready && !flush;
  assign w_pop    = w_valid && out_ready && !flush;

  assign w_rd_next = (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
  assign w_wr_next = (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;

  assign out_valid = w_valid;
  assign out_IR    = w_valid ? r_mem_ir[r_rd_ptr] : 32'h0;
  assign out_PC    = w_valid ? r_mem_pc[r_rd_ptr] : 32'h0;
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (!CLR_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_ir[i] <= 32'h0;
        r_mem_pc[i] <= 32'h0;
      end
    end else if (flush) begin
      // Stale entry contents are left in place; out_valid=0 masks them.
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) begin
        r_mem_ir[r_wr_ptr] <= in_IR;
        r_mem_pc[r_wr_ptr] <= in_PC;
        r_wr_ptr           <= w_wr_next;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_next;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 3'd1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 3'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_id_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_buffer
// Brief    : Directed self-checking bench for if_id_buffer (DEPTH=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        CLR_n;
  logic        in_valid;
  logic [31:0] in_IR;
  logic [31:0] in_PC;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_IR;
  logic [31:0] out_PC;
  logic        out_ready;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  if_id_buffer #(.DEPTH(2)) dut (
    .clk       (clk),
    .CLR_n     (CLR_n),
    .in_valid  (in_valid),
    .in_IR     (in_IR),
    .in_PC     (in_PC),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_IR    (out_IR),
    .out_PC    (out_PC),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy);
    in_valid  = v;
    in_PC     = pc;
    in_IR     = 32'hA000_0000 | pc;
    out_ready = rdy;
  endtask

  initial begin
    CLR_n = 1'b0; flush = 1'b0;
    drive(1'b0, 32'd0, 1'b0);
    step(); step();
    CLR_n = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_IR",    out_IR,         32'h0);
    chk("rst_out_PC",    out_PC,         32'h0);
    chk("rst_count",     32'(count),     32'd0);

    // Single push becomes visible one edge later.
    in_valid = 1'b1; in_IR = 32'h2008_0005; in_PC = 32'd0; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk("one_out_valid", 32'(out_valid), 32'd1);
    chk("one_out_IR",    out_IR,         32'h2008_0005);
    chk("one_out_PC",    out_PC,         32'd0);
    chk("one_count",     32'(count),     32'd1);
    chk("one_in_ready",  32'(in_ready),  32'd1);

    drive(1'b0, 32'd0, 1'b1);
    step();
    chk("pop_count", 32'(count),  32'd0);
    chk("pop_nop",   out_IR,      32'h0);
    step();
    chk("empty_pop_count", 32'(count), 32'd0);

    // Fill to capacity; third push dropped.
    drive(1'b1, 32'd0, 1'b0); step();
    chk("fill1_count", 32'(count), 32'd1);
    drive(1'b1, 32'd1, 1'b0); step();
    chk("fill2_count",    32'(count),    32'd2);
    chk("fill2_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 32'd2, 1'b0); step();
    chk("fill3_count", 32'(count), 32'd2);
    chk("fill3_head",  out_PC,     32'd0);
    drive(1'b0, 32'd0, 1'b1); step();
    chk("drain1_pc",    out_PC,     32'd1);
    chk("drain1_count", 32'(count), 32'd1);
    step();
    chk("drain2_count", 32'(count),     32'd0);
    chk("drain2_valid", 32'(out_valid), 32'd0);

    // Full with out_ready=1: pop happens, push ignored.
    drive(1'b1, 32'd10, 1'b0); step();
    drive(1'b1, 32'd11, 1'b0); step();
    drive(1'b1, 32'd12, 1'b1); step();
    chk("fullpop_count", 32'(count), 32'd1);
    chk("fullpop_head",  out_PC,     32'd11);
    drive(1'b0, 32'd0, 1'b1); step();
    chk("fullpop_drain", 32'(count), 32'd0);

    // Streaming push+pop with pointer wrap.
    drive(1'b1, 32'd0, 1'b0); step();
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 32'(k), 1'b1);
      chk("stream_head", out_PC, 32'(k - 1));
      step();
      chk("stream_count", 32'(count), 32'd1);
    end
    chk("stream_last", out_PC, 32'd8);
    chk("stream_IR",   out_IR, 32'hA000_0008);

    // Flush drops buffered and same-cycle entries.
    drive(1'b1, 32'd9, 1'b0); step();
    chk("preflush_count", 32'(count), 32'd2);
    drive(1'b1, 32'd99, 1'b1); flush = 1'b1;
    step();
    flush = 1'b0; drive(1'b0, 32'd0, 1'b0);
    chk("flush_count",    32'(count),     32'd0);
    chk("flush_valid",    32'(out_valid), 32'd0);
    chk("flush_IR",       out_IR,         32'h0);
    chk("flush_in_ready", 32'(in_ready),  32'd1);
    step();
    chk("flush_stays", 32'(count), 32'd0);
    drive(1'b1, 32'd20, 1'b0); step();
    chk("postflush_pc",    out_PC,     32'd20);
    chk("postflush_count", 32'(count), 32'd1);

    // Reset mid-operation beats push.
    drive(1'b1, 32'd21, 1'b0); step();
    chk("prerst_count", 32'(count), 32'd2);
    CLR_n = 1'b0; drive(1'b1, 32'd55, 1'b1);
    step();
    CLR_n = 1'b1; drive(1'b0, 32'd0, 1'b0);
    chk("midrst_count",    32'(count),     32'd0);
    chk("midrst_valid",    32'(out_valid), 32'd0);
    chk("midrst_PC",       out_PC,         32'h0);
    chk("midrst_in_ready", 32'(in_ready),  32'd1);
    step();
    chk("midrst_stays", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
